mem_access_unit: RTL and testbench
==================================

// Module: mem_access_unit
// PURPOSE
//  Memory-stage load/store engine. Produces the read data and the writeback stall that
//  feed the memory/writeback pipeline register.
//  Takes an address, store data and funct3 from the memory stage.
//  Runs a valid/ready request and a valid response exchange with the data cache.
//  Returns aligned, sign/zero-extended load data and stalls the pipeline until the access completes.
// PARAMETERS
//  DATA_WIDTH  64  data bus width; byte-lane logic is fixed at 8 lanes
//  ADDR_WIDTH  64  address width
// PORTS
//  i_clk         in   1           clock
//  i_arst        in   1           asynchronous active-high reset
//  i_mem_re      in   1           load in memory stage
//  i_mem_we      in   1           store in memory stage; priority over i_mem_re if both set
//  i_funct3      in   3           000 lb,001 lh,010 lw,011 ld,100 lbu,101 lhu,110 lwu,111 = ld
//  i_addr        in   ADDR_WIDTH  byte address (ALU result)
//  i_wdata       in   DATA_WIDTH  store data, LSB-justified
//  o_req_valid   out  1           cache request valid
//  i_req_ready   in   1           cache accepts request
//  o_req_addr    out  ADDR_WIDTH  doubleword-aligned address, i_addr with [2:0] = 0
//  o_req_we      out  1           1 = write
//  o_req_wdata   out  DATA_WIDTH  store data shifted left by 8*i_addr[2:0]
//  o_req_wstrb   out  8           byte strobes
//  i_rsp_valid   in   1           load response valid
//  i_rsp_rdata   in   DATA_WIDTH  load response doubleword
//  o_read_data   out  DATA_WIDTH  extended load result, registered, to writeback register
//  o_stall_wb    out  1           freeze writeback register and upstream stages
//  o_misalign    out  1           misaligned-access flag (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: state IDLE; every output 0. Reset is async; o_req_valid drops immediately.
//  - FSM IDLE -> REQ -> (WAIT) -> DONE -> IDLE.
//    - IDLE: if (re|we), register addr/wdata/strobe/funct3 and go to REQ.
//    - REQ: o_req_valid=1; fields held stable until i_req_ready.
//      - On ready: store -> DONE (posted write); load -> WAIT.
//    - WAIT: on i_rsp_valid, register the extended data into o_read_data -> DONE.
//      i_rsp_valid is ignored in every state except WAIT.
//    - DONE: unconditionally -> IDLE; the next instruction is sampled in IDLE.
//  - o_stall_wb (combinational) = (IDLE & (re|we)) | REQ | WAIT; low in DONE so the pipeline
//    advances exactly once per access.
//  - Minimum latency: load 3 stall cycles (IDLE, REQ, WAIT with same-cycle ready and response);
//    store 2 stall cycles.
//  - Extension: shift i_rsp_rdata right by 8*off, where off = addr[2:0].
//    - Then extend from bit 7 / 15 / 31 per funct3; sign-extend for lb/lh/lw, zero-extend for lbu/lhu/lwu.
//  - Strobes: sb 8'h01<<off, sh 8'h03<<off, sw 8'h0F<<off, sd 8'hFF. Bits shifted past lane 7 are dropped.
//  - o_read_data holds its last value across stores, stalls and idle cycles.
//  - No access (re=we=0): stays in IDLE, stall 0, no request.
// CONFIGURATION
//  MISALIGN_TRAP_EN defined:
//    - In IDLE, a misaligned access does not issue a request and goes directly to DONE.
//      Misaligned = h with off[0]!=0, w with off[1:0]!=0, d with off!=0.
//    - o_misalign=1 for that single DONE cycle; stall for 1 cycle; o_read_data unchanged.
//  MISALIGN_TRAP_EN undefined:
//    - o_misalign tied 0; misaligned accesses are issued as-is.
//    - Bytes beyond lane 7 are lost.
// TESTING
//  1. lw addr 0x1004, ready=1, rsp next cycle, rdata 0x80000000_12345678
//     -> req_addr 0x1000; read_data 0xFFFFFFFF_80000000; stall 1,1,1 then 0.
//  2. lbu addr 0x3003, i_req_ready low 3 cycles, rdata byte3 0x9A
//     -> req_valid held 4 cycles with stable addr; read_data 0x9A.
//  3. sh addr 0x2006 wdata 0xABCD
//     -> wstrb 8'hC0, wdata 0xABCD000000000000; no WAIT; read_data unchanged.
//  4. Reset asserted in WAIT, then i_rsp_valid
//     -> state IDLE, all outputs 0, response ignored.
//  5. MISALIGN_TRAP_EN defined, lw addr 0x1002
//     -> no req_valid; o_misalign=1 for 1 cycle; stall 1 cycle.
//  6. Back-to-back lds to 0x10 and 0x18
//     -> two requests; stall low exactly one cycle between them; both results correct.

Source files
------------

// File: rtl/mem_access_unit.sv
// Memory-stage load/store engine: cache request/response handshake, byte-lane alignment and load extension.
// Optional macro MISALIGN_TRAP_EN: misaligned accesses skip the cache and flag o_misalign for one cycle.
module mem_access_unit #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned ADDR_WIDTH = 64
) (
    input  logic                  i_clk,
    input  logic                  i_arst,
    input  logic                  i_mem_re,
    input  logic                  i_mem_we,
    input  logic [2:0]            i_funct3,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    output logic                  o_req_valid,
    input  logic                  i_req_ready,
    output logic [ADDR_WIDTH-1:0] o_req_addr,
    output logic                  o_req_we,
    output logic [DATA_WIDTH-1:0] o_req_wdata,
    output logic [7:0]            o_req_wstrb,
    input  logic                  i_rsp_valid,
    input  logic [DATA_WIDTH-1:0] i_rsp_rdata,
    output logic [DATA_WIDTH-1:0] o_read_data,
    output logic                  o_stall_wb,
    output logic                  o_misalign
);

    localparam int unsigned NUM_LANES = 8;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_e;

    state_e                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [2:0]             off_q, off_d;
    logic [2:0]             funct3_q, funct3_d;
    logic                   we_q, we_d;
    logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;
    logic [NUM_LANES-1:0]   wstrb_q, wstrb_d;
    logic [DATA_WIDTH-1:0]  rdata_q, rdata_d;
    logic                   misalign_q, misalign_d;

    logic                   access;
    logic [2:0]             off;
    logic                   misaligned;
    logic [NUM_LANES-1:0]   strobe;
    logic [DATA_WIDTH-1:0]  shifted;
    logic [DATA_WIDTH-1:0]  ext;

    assign access = i_mem_re | i_mem_we;
    assign off    = i_addr[2:0];

    // Access size is funct3[1:0] for every encoding, including 111 (= ld).
    always_comb begin
        case (i_funct3[1:0])
            2'b00:   strobe = 8'h01 << off;
            2'b01:   strobe = 8'h03 << off;
            2'b10:   strobe = 8'h0F << off;
            default: strobe = 8'hFF;
        endcase
    end

`ifdef MISALIGN_TRAP_EN
    always_comb begin
        case (i_funct3[1:0])
            2'b01:   misaligned = off[0];
            2'b10:   misaligned = |off[1:0];
            2'b11:   misaligned = |off;
            default: misaligned = 1'b0;
        endcase
    end
`else
    assign misaligned = 1'b0;
`endif

    // Load data: bring the addressed byte to lane 0, then sign/zero extend.
    always_comb begin
        shifted = i_rsp_rdata >> {off_q, 3'b000};
        case (funct3_q)
            3'b000:  ext = {{(DATA_WIDTH-8){shifted[7]}},   shifted[7:0]};
            3'b001:  ext = {{(DATA_WIDTH-16){shifted[15]}}, shifted[15:0]};
            3'b010:  ext = {{(DATA_WIDTH-32){shifted[31]}}, shifted[31:0]};
            3'b100:  ext = {{(DATA_WIDTH-8){1'b0}},         shifted[7:0]};
            3'b101:  ext = {{(DATA_WIDTH-16){1'b0}},        shifted[15:0]};
            3'b110:  ext = {{(DATA_WIDTH-32){1'b0}},        shifted[31:0]};
            default: ext = shifted;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            off_q      <= '0;
            funct3_q   <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            rdata_q    <= '0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            off_q      <= off_d;
            funct3_q   <= funct3_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            rdata_q    <= rdata_d;
            misalign_q <= misalign_d;
        end
    end

    // Stall is held through REQ/WAIT and released only in DONE, so the pipeline advances once per access.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        off_d      = off_q;
        funct3_d   = funct3_q;
        we_d       = we_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        rdata_d    = rdata_q;
        misalign_d = 1'b0;
        o_stall_wb = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (access) begin
                    o_stall_wb = 1'b1;
                    addr_d     = {i_addr[ADDR_WIDTH-1:3], 3'b000};
                    off_d      = off;
                    funct3_d   = i_funct3;
                    we_d       = i_mem_we;
                    wdata_d    = i_wdata << {off, 3'b000};
                    wstrb_d    = strobe;
                    if (misaligned) begin
                        misalign_d = 1'b1;
                        state_d    = S_DONE;
                    end else begin
                        state_d    = S_REQ;
                    end
                end
            end
            S_REQ: begin
                o_stall_wb = 1'b1;
                if (i_req_ready) begin
                    state_d = we_q ? S_DONE : S_WAIT;
                end
            end
            S_WAIT: begin
                o_stall_wb = 1'b1;
                if (i_rsp_valid) begin
                    rdata_d = ext;
                    state_d = S_DONE;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign o_req_valid = (state_q == S_REQ);
    assign o_req_addr  = addr_q;
    assign o_req_we    = we_q;
    assign o_req_wdata = wdata_q;
    assign o_req_wstrb = wstrb_q;
    assign o_read_data = rdata_q;
    assign o_misalign  = misalign_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: vector table of single accesses plus hand-written multi-cycle sequences.
module tb_mem_access_unit;

    logic        clk;
    logic        rst;
    logic        mem_re;
    logic        mem_we;
    logic [2:0]  funct3;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic        req_valid;
    logic        req_ready;
    logic [63:0] req_addr;
    logic        req_we;
    logic [63:0] req_wdata;
    logic [7:0]  req_wstrb;
    logic        rsp_valid;
    logic [63:0] rsp_rdata;
    logic [63:0] read_data;
    logic        stall_wb;
    logic        misalign;

    int n_checks = 0;
    int n_fail   = 0;

    mem_access_unit #(.DATA_WIDTH(64), .ADDR_WIDTH(64)) dut (
        .i_clk       (clk),
        .i_arst      (rst),
        .i_mem_re    (mem_re),
        .i_mem_we    (mem_we),
        .i_funct3    (funct3),
        .i_addr      (addr),
        .i_wdata     (wdata),
        .o_req_valid (req_valid),
        .i_req_ready (req_ready),
        .o_req_addr  (req_addr),
        .o_req_we    (req_we),
        .o_req_wdata (req_wdata),
        .o_req_wstrb (req_wstrb),
        .i_rsp_valid (rsp_valid),
        .i_rsp_rdata (rsp_rdata),
        .o_read_data (read_data),
        .o_stall_wb  (stall_wb),
        .o_misalign  (misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic        re;
        logic [2:0]  f3;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [63:0] rdata;
        logic [63:0] exp_req_addr;
        logic [7:0]  exp_wstrb;
        logic [63:0] exp_wdata;
        logic [63:0] exp_rd;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic add(input logic we, input logic re, input logic [2:0] f3, input logic [63:0] a,
                       input logic [63:0] wd, input logic [63:0] rd, input logic [63:0] era,
                       input logic [7:0] ews, input logic [63:0] ewd, input logic [63:0] erd);
        vec_t v;
        v.we = we; v.re = re; v.f3 = f3; v.addr = a; v.wdata = wd; v.rdata = rd;
        v.exp_req_addr = era; v.exp_wstrb = ews; v.exp_wdata = ewd; v.exp_rd = erd;
        vecs.push_back(v);
    endtask

    // One access with ready and response in the first possible cycle; entered and left at a negedge in IDLE.
    task automatic run_vec(input vec_t v, input int idx);
        mem_we = v.we; mem_re = v.re; funct3 = v.f3; addr = v.addr; wdata = v.wdata;
        req_ready = 1'b1; rsp_valid = 1'b0;
        #1;
        chk1($sformatf("v%0d_idle_stall", idx), stall_wb, 1'b1);
        chk1($sformatf("v%0d_idle_reqv", idx), req_valid, 1'b0);
        @(negedge clk); #1;
        chk1($sformatf("v%0d_req_valid", idx), req_valid, 1'b1);
        chk1($sformatf("v%0d_req_stall", idx), stall_wb, 1'b1);
        chk($sformatf("v%0d_req_addr", idx), req_addr, v.exp_req_addr);
        chk1($sformatf("v%0d_req_we", idx), req_we, v.we);
        chk($sformatf("v%0d_wstrb", idx), 64'(req_wstrb), 64'(v.exp_wstrb));
        chk($sformatf("v%0d_wdata", idx), req_wdata, v.exp_wdata);
        @(negedge clk);
        if (!v.we) begin
            rsp_valid = 1'b1; rsp_rdata = v.rdata;
            #1;
            chk1($sformatf("v%0d_wait_stall", idx), stall_wb, 1'b1);
            chk1($sformatf("v%0d_wait_reqv", idx), req_valid, 1'b0);
            @(negedge clk);
            rsp_valid = 1'b0;
        end
        mem_re = 1'b0; mem_we = 1'b0;
        #1;
        chk1($sformatf("v%0d_done_stall", idx), stall_wb, 1'b0);
        chk1($sformatf("v%0d_done_reqv", idx), req_valid, 1'b0);
        chk1($sformatf("v%0d_done_misalign", idx), misalign, 1'b0);
        chk($sformatf("v%0d_read_data", idx), read_data, v.exp_rd);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; mem_re = 1'b0; mem_we = 1'b0; funct3 = 3'b000; addr = '0; wdata = '0;
        req_ready = 1'b0; rsp_valid = 1'b0; rsp_rdata = '0;

        //   we    re    f3      addr      wdata                  rdata                  req_addr   wstrb  exp_wdata              exp_rd
        add(1'b0, 1'b1, 3'b010, 64'h1004, 64'h0,                 64'h80000000_12345678, 64'h1000, 8'hF0, 64'h0,                 64'hFFFFFFFF_80000000);
        add(1'b0, 1'b1, 3'b000, 64'h2001, 64'h0,                 64'h00000000_0000F280, 64'h2000, 8'h02, 64'h0,                 64'hFFFFFFFF_FFFFFFF2);
        add(1'b0, 1'b1, 3'b100, 64'h2001, 64'h0,                 64'h00000000_0000F280, 64'h2000, 8'h02, 64'h0,                 64'h00000000_000000F2);
        add(1'b0, 1'b1, 3'b001, 64'h2006, 64'h0,                 64'h80010000_00000000, 64'h2000, 8'hC0, 64'h0,                 64'hFFFFFFFF_FFFF8001);
        add(1'b0, 1'b1, 3'b101, 64'h2006, 64'h0,                 64'h80010000_00000000, 64'h2000, 8'hC0, 64'h0,                 64'h00000000_00008001);
        add(1'b0, 1'b1, 3'b110, 64'h1004, 64'h0,                 64'h80000000_12345678, 64'h1000, 8'hF0, 64'h0,                 64'h00000000_80000000);
        add(1'b0, 1'b1, 3'b011, 64'h4000, 64'h0,                 64'h01234567_89ABCDEF, 64'h4000, 8'hFF, 64'h0,                 64'h01234567_89ABCDEF);
        add(1'b0, 1'b1, 3'b111, 64'h4008, 64'h0,                 64'hFEDCBA98_76543210, 64'h4008, 8'hFF, 64'h0,                 64'hFEDCBA98_76543210);
        add(1'b0, 1'b1, 3'b010, 64'h1000, 64'h0,                 64'h80000000_12345678, 64'h1000, 8'h0F, 64'h0,                 64'h00000000_12345678);
        add(1'b1, 1'b0, 3'b001, 64'h2006, 64'h0000ABCD,          64'h0,                 64'h2000, 8'hC0, 64'hABCD0000_00000000, 64'h00000000_12345678);
        add(1'b1, 1'b0, 3'b000, 64'h3003, 64'hFFFFFFFF_FFFFFF5A, 64'h0,                 64'h3000, 8'h08, 64'hFFFFFFFF_5A000000, 64'h00000000_12345678);
        add(1'b1, 1'b0, 3'b011, 64'h5000, 64'h11223344_55667788, 64'h0,                 64'h5000, 8'hFF, 64'h11223344_55667788, 64'h00000000_12345678);
        add(1'b1, 1'b0, 3'b010, 64'h5004, 64'hDEADBEEF,          64'h0,                 64'h5000, 8'hF0, 64'hDEADBEEF_00000000, 64'h00000000_12345678);
        add(1'b1, 1'b1, 3'b010, 64'h5000, 64'hCAFEF00D,          64'h0,                 64'h5000, 8'h0F, 64'h00000000_CAFEF00D, 64'h00000000_12345678);
`ifndef MISALIGN_TRAP_EN
        add(1'b1, 1'b0, 3'b010, 64'h5006, 64'hDEADBEEF,          64'h0,                 64'h5000, 8'hC0, 64'hBEEF0000_00000000, 64'h00000000_12345678);
        add(1'b0, 1'b1, 3'b010, 64'h1006, 64'h0,                 64'hAABBCCDD_11223344, 64'h1000, 8'hC0, 64'h0,                 64'h00000000_0000AABB);
`endif

        // Reset values
        @(negedge clk); @(negedge clk); #1;
        chk1("rst_req_valid", req_valid, 1'b0);
        chk1("rst_stall", stall_wb, 1'b0);
        chk1("rst_misalign", misalign, 1'b0);
        chk1("rst_req_we", req_we, 1'b0);
        chk("rst_read_data", read_data, 64'h0);
        chk("rst_req_addr", req_addr, 64'h0);
        chk("rst_wstrb", 64'(req_wstrb), 64'h0);
        chk("rst_wdata", req_wdata, 64'h0);
        @(negedge clk); rst = 1'b0;

        // No access: no stall, no request
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); #1;
            chk1("noacc_stall", stall_wb, 1'b0);
            chk1("noacc_req_valid", req_valid, 1'b0);
        end
        @(negedge clk);

        foreach (vecs[i]) run_vec(vecs[i], i);

        // lbu 0x3003 with ready low for 3 cycles; a stray response in REQ must be ignored
        mem_re = 1'b1; funct3 = 3'b100; addr = 64'h3003; req_ready = 1'b0;
        #1 chk1("rdy_idle_stall", stall_wb, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            rsp_valid = (i == 1); rsp_rdata = 64'hFFFFFFFF_FFFFFFFF;
            #1;
            chk1("rdy_hold_valid", req_valid, 1'b1);
            chk("rdy_hold_addr", req_addr, 64'h3000);
            chk1("rdy_hold_stall", stall_wb, 1'b1);
        end
        @(negedge clk); rsp_valid = 1'b0; req_ready = 1'b1;
        #1;
        chk1("rdy_4th_valid", req_valid, 1'b1);
        chk("rdy_4th_addr", req_addr, 64'h3000);
        @(negedge clk); req_ready = 1'b0;
        #1;
        chk1("rdy_wait_valid", req_valid, 1'b0);
        chk1("rdy_wait_stall", stall_wb, 1'b1);
        chk("rdy_wait_rd_hold", read_data, 64'h00000000_0000AABB
`ifdef MISALIGN_TRAP_EN
            ^ 64'h00000000_0000AABB ^ 64'h00000000_12345678
`endif
        );
        @(negedge clk); rsp_valid = 1'b1; rsp_rdata = 64'h77665544_9A332211;
        #1 chk1("rdy_wait2_stall", stall_wb, 1'b1);
        @(negedge clk); rsp_valid = 1'b0; mem_re = 1'b0;
        #1;
        chk1("rdy_done_stall", stall_wb, 1'b0);
        chk("rdy_read_data", read_data, 64'h9A);
        @(negedge clk);

        // Reset asserted while waiting for a response; the late response is ignored
        mem_re = 1'b1; funct3 = 3'b010; addr = 64'h1004; req_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1 chk1("rstw_wait_stall", stall_wb, 1'b1);
        #2 rst = 1'b1; mem_re = 1'b0;
        #1;
        chk1("rstw_req_valid", req_valid, 1'b0);
        chk1("rstw_stall", stall_wb, 1'b0);
        chk("rstw_read_data", read_data, 64'h0);
        chk("rstw_req_addr", req_addr, 64'h0);
        chk("rstw_wstrb", 64'(req_wstrb), 64'h0);
        @(negedge clk); rst = 1'b0; rsp_valid = 1'b1; rsp_rdata = 64'h12345678_12345678;
        @(negedge clk); rsp_valid = 1'b0;
        #1;
        chk("rstw_rd_after", read_data, 64'h0);
        chk1("rstw_stall_after", stall_wb, 1'b0);
        chk1("rstw_reqv_after", req_valid, 1'b0);
        @(negedge clk);

        // Back-to-back ld 0x10 then 0x18
        mem_re = 1'b1; funct3 = 3'b011; addr = 64'h10; req_ready = 1'b1;
        #1 chk1("b2b_idle0_stall", stall_wb, 1'b1);
        @(negedge clk); #1;
        chk1("b2b_req0_valid", req_valid, 1'b1);
        chk("b2b_req0_addr", req_addr, 64'h10);
        @(negedge clk); rsp_valid = 1'b1; rsp_rdata = 64'h11112222_33334444;
        #1 chk1("b2b_wait0_stall", stall_wb, 1'b1);
        @(negedge clk); rsp_valid = 1'b0; addr = 64'h18;
        #1;
        chk1("b2b_done0_stall", stall_wb, 1'b0);
        chk("b2b_rd0", read_data, 64'h11112222_33334444);
        @(negedge clk); #1;
        chk1("b2b_idle1_stall", stall_wb, 1'b1);
        chk1("b2b_idle1_reqv", req_valid, 1'b0);
        @(negedge clk); #1;
        chk1("b2b_req1_valid", req_valid, 1'b1);
        chk("b2b_req1_addr", req_addr, 64'h18);
        @(negedge clk); rsp_valid = 1'b1; rsp_rdata = 64'h55556666_77778888;
        #1 chk1("b2b_wait1_stall", stall_wb, 1'b1);
        @(negedge clk); rsp_valid = 1'b0; mem_re = 1'b0;
        #1;
        chk1("b2b_done1_stall", stall_wb, 1'b0);
        chk("b2b_rd1", read_data, 64'h55556666_77778888);
        @(negedge clk); #1;
        chk1("b2b_end_stall", stall_wb, 1'b0);
        chk1("b2b_end_reqv", req_valid, 1'b0);

`ifdef MISALIGN_TRAP_EN
        // Misaligned lw traps without a cache request
        @(negedge clk);
        mem_re = 1'b1; funct3 = 3'b010; addr = 64'h1002;
        #1 chk1("trap_idle_stall", stall_wb, 1'b1);
        @(negedge clk); mem_re = 1'b0;
        #1;
        chk1("trap_req_valid", req_valid, 1'b0);
        chk1("trap_misalign", misalign, 1'b1);
        chk1("trap_done_stall", stall_wb, 1'b0);
        chk("trap_read_data", read_data, 64'h55556666_77778888);
        @(negedge clk); #1;
        chk1("trap_misalign_clr", misalign, 1'b0);
        chk1("trap_req_valid2", req_valid, 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
